// File: rtl/queue_sequencer_pkg.sv
// Shared types and widths for queue_sequencer and its bench.
package tb_pkg_defs;

    localparam int WORD_W = 8;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PUSH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/queue_sequencer_rise_detect.sv
// One-bit rising-edge detector: previous sample registered, rise = now & ~prev.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/queue_sequencer.sv
// Sequencer between serial deserializer and word queue: latches bytes, strobes push/pop, tracks occupancy.
// Optional periodic auto-drain of the queue when AUTO_DRAIN_EN is defined.
//
// state | meaning
// IDLE  | ready for a new serial byte (status high)
// HOLD  | byte held, waiting for enqueue request and a free slot
// PUSH  | one-cycle push strobe of the held byte
module queue_sequencer
    import tb_pkg_defs::*;
#(
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 1000
) (
    input  logic              i_clock_1MHz,
    input  logic              i_rst,
    input  logic              i_deser_valid,
    input  logic [WORD_W-1:0] i_deser_word,
    input  logic              i_enqueue_in,
    input  logic              i_dequeue_in,
    output logic              o_deser_ack,
    output logic              o_status_out,
    output logic              o_q_enq,
    output logic              o_q_deq,
    output logic [WORD_W-1:0] o_q_data,
    output logic [LEN_W-1:0]  o_len_out,
    output logic              o_full_out,
    output logic              o_empty_out
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    seq_state_t        r_state, w_state_next;
    logic              r_pending, w_pending_next;
    logic [WORD_W-1:0] r_hold, w_hold_next;
    logic              w_ack_next, w_enq_next;
    logic              r_deser_ack, r_status, r_q_enq, r_q_deq, r_full, r_empty;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    w_len_eff;
    logic              w_enq_rise, w_deq_rise, w_pop;

    rise_detect u_enq_rise (
        .i_clk  (i_clock_1MHz),
        .i_rst  (i_rst),
        .i_d    (i_enqueue_in),
        .o_rise (w_enq_rise)
    );

    rise_detect u_deq_rise (
        .i_clk  (i_clock_1MHz),
        .i_rst  (i_rst),
        .i_d    (i_dequeue_in),
        .o_rise (w_deq_rise)
    );

    // Occupancy including strobes currently in flight; a pop must never be granted against a word already leaving.
    assign w_len_eff = {1'b0, r_len}
                     + {{LEN_W{1'b0}}, r_q_enq}
                     - {{LEN_W{1'b0}}, r_q_deq};

`ifdef AUTO_DRAIN_EN
    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

    logic [CNT_W-1:0] r_drain_cnt;
    logic             w_drain_fire;

    assign w_drain_fire = (r_drain_cnt == CNT_W'(DRAIN_CYCLES - 1));
    assign w_pop        = (w_deq_rise | w_drain_fire) & (w_len_eff != '0);

    always_ff @(posedge i_clock_1MHz) begin
        if (i_rst)                                       r_drain_cnt <= '0;
        else if (w_pop || w_drain_fire || r_len == '0)   r_drain_cnt <= '0;
        else                                             r_drain_cnt <= r_drain_cnt + CNT_W'(1);
    end
`else
    assign w_pop = w_deq_rise & (w_len_eff != '0);
`endif

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_hold_next    = r_hold;
        w_ack_next     = 1'b0;
        w_enq_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_deser_valid) begin
                    w_hold_next  = i_deser_word;
                    w_ack_next   = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // Registered len only: a pop at full frees the slot a cycle before the deferred push.
                w_pending_next = r_pending | w_enq_rise;
                if (w_pending_next && (r_len < DEPTH_L)) begin
                    w_state_next = PUSH;
                    w_enq_next   = 1'b1;
                end
            end
            PUSH: begin
                w_pending_next = 1'b0;
                w_state_next   = IDLE;
            end
            default: begin
                w_pending_next = 1'b0;
                w_state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock_1MHz) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_hold      <= '0;
            r_deser_ack <= 1'b0;
            r_status    <= 1'b1;
            r_q_enq     <= 1'b0;
            r_q_deq     <= 1'b0;
            r_len       <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_hold      <= w_hold_next;
            r_deser_ack <= w_ack_next;
            r_status    <= (w_state_next == IDLE);
            r_q_enq     <= w_enq_next;
            r_q_deq     <= w_pop;
            r_len       <= w_len_eff[LEN_W-1:0];
            r_full      <= (w_len_eff == (LEN_W+1)'(DEPTH));
            r_empty     <= (w_len_eff == '0);
        end
    end

    assign o_deser_ack  = r_deser_ack;
    assign o_status_out = r_status;
    assign o_q_enq      = r_q_enq;
    assign o_q_deq      = r_q_deq;
    assign o_q_data     = r_hold;
    assign o_len_out    = r_len;
    assign o_full_out   = r_full;
    assign o_empty_out  = r_empty;

endmodule

// File: tb/tb_queue_sequencer.sv
// Directed self-checking bench for queue_sequencer; adds a short-period drain instance when AUTO_DRAIN_EN is defined.
module tb_queue_sequencer;
    import tb_pkg_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, deser_valid, enq, deq;
    logic [WORD_W-1:0] deser_word;
    logic              deser_ack, status, q_enq, q_deq, full, empty;
    logic [WORD_W-1:0] q_data;
    logic [LEN_W-1:0]  len;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cnt;

    queue_sequencer #(.DEPTH(8), .DRAIN_CYCLES(1000)) dut (
        .i_clock_1MHz (clk),
        .i_rst        (rst),
        .i_deser_valid(deser_valid),
        .i_deser_word (deser_word),
        .i_enqueue_in (enq),
        .i_dequeue_in (deq),
        .o_deser_ack  (deser_ack),
        .o_status_out (status),
        .o_q_enq      (q_enq),
        .o_q_deq      (q_deq),
        .o_q_data     (q_data),
        .o_len_out    (len),
        .o_full_out   (full),
        .o_empty_out  (empty)
    );

`ifdef AUTO_DRAIN_EN
    logic              d_rst, d_valid, d_enq, d_deq;
    logic [WORD_W-1:0] d_word;
    logic              d_ack, d_status, d_q_enq, d_q_deq, d_full, d_empty;
    logic [WORD_W-1:0] d_q_data;
    logic [LEN_W-1:0]  d_len;

    queue_sequencer #(.DEPTH(8), .DRAIN_CYCLES(20)) dut_drain (
        .i_clock_1MHz (clk),
        .i_rst        (d_rst),
        .i_deser_valid(d_valid),
        .i_deser_word (d_word),
        .i_enqueue_in (d_enq),
        .i_dequeue_in (d_deq),
        .o_deser_ack  (d_ack),
        .o_status_out (d_status),
        .o_q_enq      (d_q_enq),
        .o_q_deq      (d_q_deq),
        .o_q_data     (d_q_data),
        .o_len_out    (d_len),
        .o_full_out   (d_full),
        .o_empty_out  (d_empty)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Load one byte, pulse enqueue, end back in IDLE with len updated.
    task automatic push_word(input logic [WORD_W-1:0] w, input string tag);
        deser_valid = 1'b1;
        deser_word  = w;
        step();
        chk({tag, "_ack"}, 32'(deser_ack), 32'd1);
        deser_valid = 1'b0;
        step();
        enq = 1'b1;
        step();
        chk({tag, "_qenq"}, 32'(q_enq), 32'd1);
        chk({tag, "_qdata"}, 32'(q_data), 32'(w));
        enq = 1'b0;
        step();
    endtask

`ifdef AUTO_DRAIN_EN
    task automatic d_push(input logic [WORD_W-1:0] w);
        d_valid = 1'b1;
        d_word  = w;
        step();
        chk("d_ack", 32'(d_ack), 32'd1);
        d_valid = 1'b0;
        step();
        d_enq = 1'b1;
        step();
        chk("d_qdata", 32'(d_q_data), 32'(w));
        d_enq = 1'b0;
        step();
    endtask
`endif

    initial begin
        rst = 1'b1; deser_valid = 1'b0; deser_word = '0; enq = 1'b0; deq = 1'b0;
`ifdef AUTO_DRAIN_EN
        d_rst = 1'b1; d_valid = 1'b0; d_word = '0; d_enq = 1'b0; d_deq = 1'b0;
`endif
        step();
        step();

        // reset state
        chk("rst_status", 32'(status), 32'd1);
        chk("rst_ack",    32'(deser_ack), 32'd0);
        chk("rst_qenq",   32'(q_enq), 32'd0);
        chk("rst_qdeq",   32'(q_deq), 32'd0);
        chk("rst_qdata",  32'(q_data), 32'd0);
        chk("rst_len",    32'(len), 32'd0);
        chk("rst_full",   32'(full), 32'd0);
        chk("rst_empty",  32'(empty), 32'd1);
        rst = 1'b0;
        step();

        // first byte 0xAA
        deser_valid = 1'b1;
        deser_word  = 8'hAA;
        step();
        chk("aa_ack_hi", 32'(deser_ack), 32'd1);
        chk("aa_status_lo", 32'(status), 32'd0);
        deser_valid = 1'b0;
        step();
        chk("aa_ack_lo", 32'(deser_ack), 32'd0);
        chk("aa_hold_status", 32'(status), 32'd0);
        enq = 1'b1;
        step();
        chk("aa_qenq", 32'(q_enq), 32'd1);
        chk("aa_qdata", 32'(q_data), 32'hAA);
        chk("aa_len_pre", 32'(len), 32'd0);
        enq = 1'b0;
        step();
        chk("aa_qenq_lo", 32'(q_enq), 32'd0);
        chk("aa_len", 32'(len), 32'd1);
        chk("aa_status_hi", 32'(status), 32'd1);

        // pop it back out: strobe next cycle, len the cycle after
        deq = 1'b1;
        step();
        chk("pop_aa_qdeq", 32'(q_deq), 32'd1);
        chk("pop_aa_len_pre", 32'(len), 32'd1);
        deq = 1'b0;
        step();
        chk("pop_aa_qdeq_lo", 32'(q_deq), 32'd0);
        chk("pop_aa_len", 32'(len), 32'd0);
        chk("pop_aa_empty", 32'(empty), 32'd1);

        // fill to full with 0x01..0x08
        for (int i = 1; i <= 8; i++) push_word(8'(i), "fill");
        chk("fill_len", 32'(len), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // ninth word is deferred while full
        deser_valid = 1'b1;
        deser_word  = 8'h09;
        step();
        deser_valid = 1'b0;
        enq = 1'b1;
        step();
        enq = 1'b0;
        cnt = (q_enq === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (q_enq === 1'b1) cnt++;
        end
        chk("full_no_qenq", 32'(cnt), 32'd0);
        chk("full_status", 32'(status), 32'd0);
        chk("full_len_held", 32'(len), 32'd8);
        deq = 1'b1;
        step();
        chk("full_qdeq", 32'(q_deq), 32'd1);
        chk("full_qenq_apart", 32'(q_enq), 32'd0);
        deq = 1'b0;
        step();
        chk("full_len7", 32'(len), 32'd7);
        chk("full_qenq_wait", 32'(q_enq), 32'd0);
        step();
        chk("deferred_qenq", 32'(q_enq), 32'd1);
        chk("deferred_qdata", 32'(q_data), 32'h09);
        step();
        chk("deferred_len", 32'(len), 32'd8);
        chk("deferred_status", 32'(status), 32'd1);
        chk("deferred_full", 32'(full), 32'd1);

        // drain all eight
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            deq = 1'b1;
            step();
            if (q_deq === 1'b1) cnt++;
            deq = 1'b0;
            step();
        end
        chk("drain_pops", 32'(cnt), 32'd8);
        chk("drain_len", 32'(len), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // dequeue on empty is ignored
        deq = 1'b1;
        step();
        chk("empty_no_qdeq", 32'(q_deq), 32'd0);
        deq = 1'b0;
        step();
        chk("empty_len", 32'(len), 32'd0);

        // enqueue level held high acts once
        deser_valid = 1'b1;
        deser_word  = 8'h5A;
        step();
        deser_valid = 1'b0;
        enq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (q_enq === 1'b1) cnt++;
        end
        enq = 1'b0;
        step();
        chk("level_one_qenq", 32'(cnt), 32'd1);
        chk("level_len", 32'(len), 32'd1);

        // simultaneous push and pop at len 3
        push_word(8'h21, "p3a");
        push_word(8'h22, "p3b");
        chk("both_len_pre", 32'(len), 32'd3);
        deser_valid = 1'b1;
        deser_word  = 8'h77;
        step();
        deser_valid = 1'b0;
        step();
        enq = 1'b1;
        deq = 1'b1;
        step();
        chk("both_qenq", 32'(q_enq), 32'd1);
        chk("both_qdeq", 32'(q_deq), 32'd1);
        chk("both_qdata", 32'(q_data), 32'h77);
        enq = 1'b0;
        deq = 1'b0;
        step();
        chk("both_len", 32'(len), 32'd3);

        // reset in HOLD
        deser_valid = 1'b1;
        deser_word  = 8'h99;
        step();
        deser_valid = 1'b0;
        chk("hold_status", 32'(status), 32'd0);
        rst = 1'b1;
        step();
        chk("midrst_status", 32'(status), 32'd1);
        chk("midrst_len", 32'(len), 32'd0);
        chk("midrst_ack", 32'(deser_ack), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        step();
        chk("post_rst_ack", 32'(deser_ack), 32'd0);

`ifdef AUTO_DRAIN_EN
        begin
            int t0, first, second, n;
            d_rst = 1'b0;
            step();
            d_push(8'h11);
            t0 = cyc;
            chk("d_len1", 32'(d_len), 32'd1);
            d_push(8'h12);
            chk("d_len2", 32'(d_len), 32'd2);
            n = 0; first = -1; second = -1;
            while (cyc - t0 < 80) begin
                step();
                if (d_q_deq === 1'b1) begin
                    n++;
                    if (n == 1) first = cyc - t0;
                    else if (n == 2) second = cyc - t0;
                end
            end
            chk("d_pulses", 32'(n), 32'd2);
            chk("d_first", 32'(first), 32'd20);
            chk("d_second", 32'(second), 32'd40);
            chk("d_len0", 32'(d_len), 32'd0);
            chk("d_empty", 32'(d_empty), 32'd1);
            chk("d_full", 32'(d_full), 32'd0);
            chk("d_status", 32'(d_status), 32'd1);
            chk("d_qenq", 32'(d_q_enq), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
